// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state codes, RV32I
// size/sign codes, and helpers for access legality and byte-lane enables.
package lsu_pkg;

    // FSM state codes
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef logic [1:0] lsu_state_t;

    // funct3 size/sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when funct3 is legal for the direction and the address is
    // naturally aligned for the access size.
    function automatic logic access_ok(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] offset);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~offset[0];
            F3_W:    ok = (offset == 2'b00);
            F3_BU:   ok = ~we;
            F3_HU:   ok = ~we & ~offset[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-lane enables; signedness does not affect the lanes touched.
    function automatic logic [3:0] byte_enable(input logic [2:0] funct3,
                                               input logic [1:0] offset);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << offset;
            2'b01:   be = offset[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword from a read word and sign- or
// zero-extends it according to funct3. Purely combinational.
module load_extend
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    // Extend the selected field to full width
    always_comb begin
        case (funct3)
            F3_B:    result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_BU:   result = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_H:    result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_HU:   result = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time, checks legality and
// alignment, drives a single word-wide memory request, and returns a
// one-cycle response with the extended load data or an error flag.
//
//   state | meaning
//   IDLE  | ready for a request; req_ready high
//   REQ   | mem_valid high, holding address/lanes/data until mem_ready
//   WAIT  | load issued, waiting for mem_rvalid
//   RESP  | rsp_valid pulse for one cycle, then back to IDLE
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    lsu_state_t      state;
    logic [2:0]      r_funct3;
    logic [1:0]      r_offset;
    logic [XLEN-1:0] store_lanes;
    logic [XLEN-1:0] load_result;
    logic            req_ok;

    assign req_ready = (state == ST_IDLE);
    assign req_ok    = access_ok(req_we, req_funct3, req_addr[1:0]);

    // Replicate store data across lanes; mem_be picks the live lanes
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   store_lanes = {(XLEN/8){req_wdata[7:0]}};
            2'b01:   store_lanes = {(XLEN/16){req_wdata[15:0]}};
            default: store_lanes = req_wdata;
        endcase
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata  (mem_rdata),
        .offset (r_offset),
        .funct3 (r_funct3),
        .result (load_result)
    );

    // Transaction FSM with registered memory and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            r_funct3  <= 3'b000;
            r_offset  <= 2'b00;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_funct3 <= req_funct3;
                        r_offset <= req_addr[1:0];
                        if (req_ok) begin
                            state     <= ST_REQ;
                            mem_valid <= 1'b1;
                            mem_we    <= req_we;
                            mem_be    <= byte_enable(req_funct3, req_addr[1:0]);
                            mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                            mem_wdata <= store_lanes;
                        end else begin
                            // Rejected requests never touch memory
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (mem_we) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= '0;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_result;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table, hand-written reset
// and back-to-back sequences, and randomized transactions checked against
// an arithmetic reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_valid, mem_ready, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int failures = 0;

    load_store_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        int          rdy, rv;
        logic        exp_mem;
        logic [3:0]  be;
        logic [31:0] maddr, mwdata, rsp;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic        saw_mem, we;
        logic [3:0]  be;
        logic [31:0] addr, wdata, rdata;
        logic        err;
        int          lat;
        logic        unstable, ready_bad, pulse_bad, timeout;
    } obs_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference model: expectations from access size, offset and signedness
    function automatic vec_t ref_model(input vec_t v);
        vec_t        e = v;
        int          size, off;
        logic        legal;
        logic [31:0] mask, val;
        off = int'(v.addr % 4);
        case (v.f3 % 4)
            0: size = 1;
            1: size = 2;
            2: size = 4;
            default: size = 0;
        endcase
        legal = v.we ? (v.f3 <= 2) : (v.f3 != 3 && v.f3 != 6 && v.f3 != 7);
        e.err = !legal || (off % size != 0);
        e.exp_mem = !e.err;
        e.be = '0; e.maddr = '0; e.mwdata = '0; e.rsp = '0;
        if (e.err) e.lat = 1;
        else begin
            e.maddr = v.addr - 32'(off);
            e.be = 4'(((1 << size) - 1) << off);
            if (size == 1)      e.mwdata = (v.wdata & 32'hFF) * 32'h01010101;
            else if (size == 2) e.mwdata = (v.wdata & 32'hFFFF) * 32'h00010001;
            else                e.mwdata = v.wdata;
            if (v.we) e.lat = 2 + v.rdy;
            else begin
                e.lat = 3 + v.rdy + v.rv;
                mask = (size == 4) ? 32'hFFFFFFFF : 32'((1 << (8 * size)) - 1);
                val = (v.rdata >> (8 * off)) & mask;
                if (v.f3 < 4 && size < 4 && val > (mask >> 1)) val = val | ~mask;
                e.rsp = val;
            end
        end
        return e;
    endfunction

    // Issue one request and act as memory with the given stall pattern
    task automatic run_txn(input vec_t v, output obs_t o);
        int c, reqc, wc;
        bit hs, first, done;
        o = '{default: 0};
        if (!req_ready) o.ready_bad = 1;
        req_valid = 1; req_we = v.we; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata; mem_rdata = v.rdata;
        @(posedge clk); #1;
        req_valid = 0; req_addr = $urandom(); req_wdata = $urandom(); req_funct3 = 3'($urandom_range(7));
        c = 1; reqc = 0; wc = 0; hs = 0; first = 1; done = 0;
        while (!done && c <= 50) begin
            if (rsp_valid) begin
                o.lat = c; o.rdata = rsp_rdata; o.err = rsp_err; done = 1;
            end else begin
                if (req_ready) o.ready_bad = 1;
                if (mem_valid) begin
                    if (first) begin
                        o.be = mem_be; o.addr = mem_addr; o.wdata = mem_wdata; o.we = mem_we;
                        first = 0;
                    end else if (o.be !== mem_be || o.addr !== mem_addr ||
                                 o.wdata !== mem_wdata || o.we !== mem_we)
                        o.unstable = 1;
                    o.saw_mem = 1;
                    mem_ready = (reqc >= v.rdy);
                    if (mem_ready) hs = 1;
                    reqc++;
                    mem_rvalid = 0;
                end else begin
                    mem_ready = 0;
                    if (hs && !v.we) begin
                        mem_rvalid = (wc == v.rv);
                        wc++;
                    end else mem_rvalid = 0;
                end
                @(posedge clk); #1;
                c++;
            end
        end
        mem_ready = 0; mem_rvalid = 0;
        if (!done) o.timeout = 1;
        else begin
            @(posedge clk); #1;
            if (rsp_valid || !req_ready || mem_valid) o.pulse_bad = 1;
        end
    endtask

    task automatic check_txn(input string tag, input vec_t v, input obs_t o);
        chk({tag, " timeout"}, o.timeout, 0);
        chk({tag, " latency"}, o.lat, v.lat);
        chk({tag, " rsp_err"}, o.err, v.err);
        chk({tag, " rsp_rdata"}, o.rdata, v.rsp);
        chk({tag, " mem_access"}, o.saw_mem, v.exp_mem);
        chk({tag, " req_ready"}, o.ready_bad, 0);
        chk({tag, " rsp_pulse"}, o.pulse_bad, 0);
        if (v.exp_mem) begin
            chk({tag, " mem_be"}, o.be, v.be);
            chk({tag, " mem_addr"}, o.addr, v.maddr);
            chk({tag, " mem_we"}, o.we, v.we);
            chk({tag, " stable"}, o.unstable, 0);
            if (v.we) chk({tag, " mem_wdata"}, o.wdata, v.mwdata);
        end
    endtask

    vec_t vecs[13];

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        vec_t v;
        logic bad;

        // we, f3, addr, wdata, rdata, rdy, rv, exp_mem, be, maddr, mwdata, rsp, err, lat
        vecs[0]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80AABBCC, 0, 0, 1'b1, 4'b1000, 32'h100, 32'h0,        32'hFFFFFF80, 1'b0, 3};
        vecs[1]  = '{1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        0, 0, 1'b1, 4'b1100, 32'h200, 32'hABCDABCD, 32'h0,        1'b0, 2};
        vecs[2]  = '{1'b0, 3'b010, 32'h105, 32'h0,        32'h0,        0, 0, 1'b0, 4'b0000, 32'h0,   32'h0,        32'h0,        1'b1, 1};
        vecs[3]  = '{1'b0, 3'b100, 32'h101, 32'h0,        32'h80AABBCC, 0, 0, 1'b1, 4'b0010, 32'h100, 32'h0,        32'h000000BB, 1'b0, 3};
        vecs[4]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80AABBCC, 0, 0, 1'b1, 4'b1100, 32'h100, 32'h0,        32'hFFFF80AA, 1'b0, 3};
        vecs[5]  = '{1'b0, 3'b101, 32'h100, 32'h0,        32'h1234F00D, 0, 0, 1'b1, 4'b0011, 32'h100, 32'h0,        32'h0000F00D, 1'b0, 3};
        vecs[6]  = '{1'b1, 3'b000, 32'h003, 32'h000000A5, 32'h0,        0, 0, 1'b1, 4'b1000, 32'h0,   32'hA5A5A5A5, 32'h0,        1'b0, 2};
        vecs[7]  = '{1'b1, 3'b010, 32'h040, 32'hDEADBEEF, 32'h0,        0, 0, 1'b1, 4'b1111, 32'h40,  32'hDEADBEEF, 32'h0,        1'b0, 2};
        vecs[8]  = '{1'b0, 3'b010, 32'h044, 32'h0,        32'hCAFEF00D, 0, 0, 1'b1, 4'b1111, 32'h44,  32'h0,        32'hCAFEF00D, 1'b0, 3};
        vecs[9]  = '{1'b1, 3'b011, 32'h000, 32'h11111111, 32'h0,        0, 0, 1'b0, 4'b0000, 32'h0,   32'h0,        32'h0,        1'b1, 1};
        vecs[10] = '{1'b0, 3'b110, 32'h000, 32'h0,        32'h12345678, 0, 0, 1'b0, 4'b0000, 32'h0,   32'h0,        32'h0,        1'b1, 1};
        vecs[11] = '{1'b1, 3'b001, 32'h201, 32'h0000BEEF, 32'h0,        0, 0, 1'b0, 4'b0000, 32'h0,   32'h0,        32'h0,        1'b1, 1};
        vecs[12] = '{1'b0, 3'b101, 32'h010, 32'h0,        32'h0000F00D, 3, 2, 1'b1, 4'b0011, 32'h10,  32'h0,        32'h0000F00D, 1'b0, 8};

        rst_n = 0; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        #12;
        chk("reset mem_valid", mem_valid, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset mem_be", mem_be, 0);
        chk("reset mem_addr", mem_addr, 0);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        chk("reset req_ready", req_ready, 1);

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i], o);
            check_txn($sformatf("vec%0d", i), vecs[i], o);
        end

        // Reset while waiting for read data, then a late rvalid
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h80; req_wdata = 0;
        @(posedge clk); #1 req_valid = 0; mem_ready = 1;
        @(posedge clk); #1 mem_ready = 0;
        chk("pre-reset in wait", mem_addr, 32'h80);
        #2 rst_n = 0;
        #1;
        chk("midreset mem_valid", mem_valid, 0);
        chk("midreset mem_we", mem_we, 0);
        chk("midreset mem_be", mem_be, 0);
        chk("midreset mem_addr", mem_addr, 0);
        chk("midreset mem_wdata", mem_wdata, 0);
        chk("midreset rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        chk("postreset req_ready", req_ready, 1);
        mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            mem_rvalid = 0;
            if (rsp_valid || !req_ready) bad = 1;
        end
        chk("late rvalid ignored", bad, 0);
        v = '{1'b0, 3'b010, 32'h84, 32'h0, 32'h13579BDF, 0, 0, 1'b0, 4'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0};
        v = ref_model(v);
        run_txn(v, o);
        check_txn("post-reset LW", v, o);

        // Back-to-back store then load
        v = '{1'b1, 3'b010, 32'h300, 32'h89ABCDEF, 32'h0, 0, 0, 1'b0, 4'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0};
        v = ref_model(v);
        run_txn(v, o);
        check_txn("b2b SW", v, o);
        v = '{1'b0, 3'b100, 32'h302, 32'h0, 32'h00C30000, 0, 0, 1'b0, 4'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0};
        v = ref_model(v);
        run_txn(v, o);
        check_txn("b2b LBU", v, o);

        // Randomized transactions
        for (int i = 0; i < 60; i++) begin
            logic [31:0] t;
            t = $urandom();
            v.we = 1'($urandom_range(1));
            v.f3 = 3'($urandom_range(7));
            v.addr = (t & 32'hFFFFFFFC) | (t[31] ? 32'h0 : 32'($urandom_range(3)));
            v.wdata = $urandom();
            v.rdata = $urandom();
            v.rdy = $urandom_range(2);
            v.rv = $urandom_range(2);
            v = ref_model(v);
            run_txn(v, o);
            check_txn($sformatf("rand%0d we=%0d f3=%0d addr=%08h", i, v.we, v.f3, v.addr), v, o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter XLEN, default 32: data and address width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  core presents a load/store request.
REQ-005 req_ready  out  1  unit can accept a request.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RV32I size/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-008 req_addr  in  XLEN  byte address.
REQ-009 req_wdata  in  XLEN  store data, right-aligned.
REQ-010 mem_valid  out  1  request to data memory.
REQ-011 mem_ready  in  1  memory accepts request.
REQ-012 mem_we  out  1  memory write enable.
REQ-013 mem_be  out  4  byte-lane enables.
REQ-014 mem_addr  out  XLEN  word-aligned address (bits [1:0] = 0).
REQ-015 mem_wdata  out  XLEN  lane-positioned store data.
REQ-016 mem_rvalid  in  1  read data valid.
REQ-017 mem_rdata  in  XLEN  read word.
REQ-018 rsp_valid  out  1  one-cycle completion pulse.
REQ-019 rsp_rdata  out  XLEN  extended load result (feeds writeback result select "read data" input); 0 for stores and errors.
REQ-020 rsp_err  out  1  valid with rsp_valid; misaligned or illegal funct3.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT, RESP; req_ready = (state == IDLE).
REQ-022 IDLE: on req_valid, SHALL register we/funct3/addr/wdata; legal and aligned -> REQ, else -> RESP with err=1 and no memory access.
REQ-023 Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. Illegal: load funct3 011/110/111, store funct3 > 010.
REQ-024 REQ: mem_valid=1 with stable mem_addr/mem_we/mem_be/mem_wdata until mem_ready; on mem_ready store -> RESP, load -> WAIT.
REQ-025 WAIT: mem_rvalid SHALL only be sampled in WAIT (earliest one cycle after handshake); on mem_rvalid capture extended data -> RESP.
REQ-026 RESP: rsp_valid=1 for exactly one cycle, then -> IDLE; new request accepted earliest the following cycle.
REQ-027 Store lanes: SB be=0001<<addr[1:0], data byte replicated x4; SH be=0011 (addr[1]=0) or 1100, halfword replicated x2; SW be=1111.
REQ-028 Loads: mem_be per REQ-027; select byte/half at addr[1:0]*8; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-029 Zero-wait load latency: accept cycle N, mem handshake N+1, rvalid N+2, rsp_valid N+3; store rsp_valid N+2.
REQ-030 mem_valid, rsp_valid SHALL be 0 outside REQ/RESP respectively; outputs registered, no combinational path req_* -> mem_*.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, mem_valid=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 after release.
REQ-032 Reset mid-transaction SHALL abandon it with no response; late mem_rvalid after reset is ignored.

Structure
REQ-033 Package lsu_pkg SHALL hold the state enum and funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-034 Sub-module load_extend (combinational: rdata, addr[1:0], funct3 -> extended result) SHALL be instantiated once.

Verification
REQ-035 LB addr 0x103, mem_rdata 0x80AABBCC -> mem_addr 0x100, be 1000, rsp_rdata 0xFFFFFF80, err 0.
REQ-036 SH addr 0x202, wdata 0x1234ABCD -> be 1100, mem_wdata 0xABCDABCD, we 1, rsp_valid at N+2.
REQ-037 LW addr 0x105 -> no mem_valid, rsp_valid at N+1 with err 1, rdata 0.
REQ-038 LHU addr 0x10, mem_ready held low 3 cycles, rvalid 2 cycles late, rdata 0x0000F00D -> mem signals stable while stalled, rsp_rdata 0x0000F00D, req_ready 0 throughout.
REQ-039 rst_n asserted in WAIT, then rvalid pulse -> all outputs at reset values, no rsp_valid, next LW completes normally.
REQ-040 Back-to-back SW then LBU -> second accepted cycle after first rsp_valid; both responses correct.
